mem_bus_scheduler: RTL and testbench

- Shares the single Sysbus master port between instruction fetch (ibus) and data memory (dbus).
- Owns the bus for one whole transaction: the request phase, then all response beats.
- Round-robin between requesters, so a stream of dcache misses cannot starve fetch and vice versa.
- Sits between fetcher/datamemory and the top-level bus pins.

---
 rtl/mem_bus_sched_pkg.sv | 23 ++
 rtl/mem_bus_scheduler_rr_pick2.sv | 26 ++
 rtl/mem_bus_scheduler.sv | 189 ++++++++++++++++++
 tb/tb_mem_bus_scheduler.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_sched_pkg.sv
// Shared types for the Sysbus master-port scheduler.
// FSM states, owner encoding and beat-counter sizing.
package mem_bus_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } state_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } owner_t;

  // Room for 1 address beat plus a full line of write data.
  function automatic int cnt_width(input int beats);
    return $clog2(beats + 2);
  endfunction

  localparam int CNT_W_DEF = cnt_width(8);

endpackage

// File: rtl/mem_bus_scheduler_rr_pick2.sv
// Two-way round-robin picker: on a tie the requester that did
// not own the bus last wins. Ports: req_i, req_d, last_owner -> valid, winner.
import mem_bus_sched_pkg::*;

module rr_pick2 (
  input  logic   req_i,
  input  logic   req_d,
  input  owner_t last_owner,
  output logic   valid,
  output owner_t winner
);

  always_comb begin
    valid  = req_i | req_d;
    winner = OWN_I;
    unique case (1'b1)
      (req_i & req_d):
        winner = (last_owner == OWN_I) ? OWN_D : OWN_I;
      (req_d & ~req_i):
        winner = OWN_D;
      default:
        winner = OWN_I;
    endcase
  end

endmodule

// File: rtl/mem_bus_scheduler.sv
// Shares one Sysbus master port between ibus and dbus, one whole
// transaction at a time, round-robin. Ports: ibus_*, dbus_* (requesters),
// bus_* (master pins), perf_* counters (built with MEM_BUS_SCHED_PERF_EN).
import mem_bus_sched_pkg::*;

module mem_bus_scheduler #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int LINE_BEATS     = 8,
  parameter int WRITE_TAG_BIT  = 12
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ibus_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] ibus_req,
  input  logic [BUS_TAG_WIDTH-1:0]  ibus_reqtag,
  output logic                      ibus_reqack,
  output logic                      ibus_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] ibus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  ibus_resptag,
  input  logic                      ibus_respack,
  input  logic                      dbus_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] dbus_req,
  input  logic [BUS_TAG_WIDTH-1:0]  dbus_reqtag,
  output logic                      dbus_reqack,
  output logic                      dbus_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] dbus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  dbus_resptag,
  input  logic                      dbus_respack,
  output logic                      bus_reqcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_reqack,
  input  logic                      bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  output logic                      bus_respack,
  output logic [31:0]               perf_igrant,
  output logic [31:0]               perf_dgrant,
  output logic [31:0]               perf_wait
);

  localparam int CW = cnt_width(LINE_BEATS);
  localparam logic [CW-1:0] LAST_W = CW'(LINE_BEATS);
  localparam logic [CW-1:0] LAST_R = CW'(LINE_BEATS - 1);

  state_t         state;
  owner_t         owner;
  owner_t         last_owner;
  logic [CW-1:0]  cnt;
  logic           is_write;

  logic           pick_valid;
  owner_t         pick;

  logic           sel_d;
  logic           in_req;
  logic           in_resp;
  logic           own_reqcyc;
  logic           oth_reqcyc;
  logic           own_respack;
  logic           req_beat;
  logic           resp_beat;
  logic           pick_wr;

  rr_pick2 u_pick (
    .req_i      (ibus_reqcyc),
    .req_d      (dbus_reqcyc),
    .last_owner (last_owner),
    .valid      (pick_valid),
    .winner     (pick)
  );

  assign sel_d   = (owner == OWN_D);
  assign in_req  = (state == REQ);
  assign in_resp = (state == RESP);

  assign own_reqcyc  = sel_d ? dbus_reqcyc  : ibus_reqcyc;
  assign oth_reqcyc  = sel_d ? ibus_reqcyc  : dbus_reqcyc;
  assign own_respack = sel_d ? dbus_respack : ibus_respack;

  assign pick_wr = (pick == OWN_D)
                 ? dbus_reqtag[WRITE_TAG_BIT]
                 : ibus_reqtag[WRITE_TAG_BIT];

  // Request path: pass-through only while the owner holds REQ.
  assign bus_reqcyc = in_req & own_reqcyc;
  assign bus_req    = !in_req ? '0 :
                      sel_d ? dbus_req : ibus_req;
  assign bus_reqtag = !in_req ? '0 :
                      sel_d ? dbus_reqtag : ibus_reqtag;

  assign ibus_reqack = in_req & ~sel_d & bus_reqack;
  assign dbus_reqack = in_req &  sel_d & bus_reqack;

  // Response data fans out to both; only respcyc is steered.
  assign ibus_resp    = bus_resp;
  assign dbus_resp    = bus_resp;
  assign ibus_resptag = bus_resptag;
  assign dbus_resptag = bus_resptag;

  assign ibus_respcyc = in_resp & ~sel_d & bus_respcyc;
  assign dbus_respcyc = in_resp &  sel_d & bus_respcyc;

  // Outside RESP nobody owns a response, so drain strays.
  assign bus_respack = in_resp ? own_respack : bus_respcyc;

  assign req_beat  = bus_reqcyc & bus_reqack;
  assign resp_beat = in_resp & bus_respcyc & own_respack;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      owner      <= OWN_D;
      last_owner <= OWN_I;
      cnt        <= '0;
      is_write   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_valid) begin
            owner    <= pick;
            is_write <= pick_wr;
            cnt      <= '0;
            state    <= REQ;
          end
        end
        REQ: begin
          if (req_beat) begin
            if (!is_write) begin
              cnt   <= '0;
              state <= RESP;
            end else if (cnt == LAST_W) begin
              cnt        <= '0;
              last_owner <= owner;
              state      <= IDLE;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        RESP: begin
          if (resp_beat) begin
            if (cnt == LAST_R) begin
              cnt        <= '0;
              last_owner <= owner;
              state      <= IDLE;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_BUS_SCHED_PERF_EN
  logic grant_i;
  logic grant_d;
  logic wait_oth;
  logic stray;

  assign grant_i  = (state == IDLE) & pick_valid & (pick == OWN_I);
  assign grant_d  = (state == IDLE) & pick_valid & (pick == OWN_D);
  assign wait_oth = (state != IDLE) & oth_reqcyc;
  assign stray    = bus_respcyc & ~in_resp;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_igrant <= '0;
      perf_dgrant <= '0;
      perf_wait   <= '0;
    end else begin
      perf_igrant <= perf_igrant + 32'(grant_i);
      perf_dgrant <= perf_dgrant + 32'(grant_d);
      perf_wait   <= perf_wait + 32'(wait_oth)
                   + 32'(stray);
    end
  end
`else
  logic unused_perf;
  assign unused_perf = oth_reqcyc;
  assign perf_igrant = '0;
  assign perf_dgrant = '0;
  assign perf_wait   = '0;
`endif

endmodule

// File: tb/tb_mem_bus_scheduler.sv
// Directed bench for mem_bus_scheduler: vector table plus
// hand sequences for arbitration, writes, waiting and reset.
module tb_mem_bus_scheduler;

`ifdef MEM_BUS_SCHED_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        ibus_reqcyc, dbus_reqcyc;
  logic [63:0] ibus_req, dbus_req;
  logic [12:0] ibus_reqtag, dbus_reqtag;
  logic        ibus_reqack, dbus_reqack;
  logic        ibus_respcyc, dbus_respcyc;
  logic [63:0] ibus_resp, dbus_resp;
  logic [12:0] ibus_resptag, dbus_resptag;
  logic        ibus_respack, dbus_respack;
  logic        bus_reqcyc;
  logic [63:0] bus_req;
  logic [12:0] bus_reqtag;
  logic        bus_reqack;
  logic        bus_respcyc;
  logic [63:0] bus_resp;
  logic [12:0] bus_resptag;
  logic        bus_respack;
  logic [31:0] perf_igrant, perf_dgrant, perf_wait;

  always #5 clk = ~clk;

  mem_bus_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .ibus_reqcyc  (ibus_reqcyc),
    .ibus_req     (ibus_req),
    .ibus_reqtag  (ibus_reqtag),
    .ibus_reqack  (ibus_reqack),
    .ibus_respcyc (ibus_respcyc),
    .ibus_resp    (ibus_resp),
    .ibus_resptag (ibus_resptag),
    .ibus_respack (ibus_respack),
    .dbus_reqcyc  (dbus_reqcyc),
    .dbus_req     (dbus_req),
    .dbus_reqtag  (dbus_reqtag),
    .dbus_reqack  (dbus_reqack),
    .dbus_respcyc (dbus_respcyc),
    .dbus_resp    (dbus_resp),
    .dbus_resptag (dbus_resptag),
    .dbus_respack (dbus_respack),
    .bus_reqcyc   (bus_reqcyc),
    .bus_req      (bus_req),
    .bus_reqtag   (bus_reqtag),
    .bus_reqack   (bus_reqack),
    .bus_respcyc  (bus_respcyc),
    .bus_resp     (bus_resp),
    .bus_resptag  (bus_resptag),
    .bus_respack  (bus_respack),
    .perf_igrant  (perf_igrant),
    .perf_dgrant  (perf_dgrant),
    .perf_wait    (perf_wait)
  );

  typedef struct {
    logic       ir;
    logic       dr;
    logic       ba;
    logic       br;
    logic       ia;
    logic       da;
    logic [5:0] ex;
  } vec_t;

  vec_t tbl [13];

  int n_chk  = 0;
  int n_fail = 0;
  int e_ig   = 0;
  int e_dg   = 0;
  int e_wt   = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_perf(input string nm);
    chk({nm, "_ig"}, {32'h0, perf_igrant},
        PERF ? 64'(e_ig) : 64'd0);
    chk({nm, "_dg"}, {32'h0, perf_dgrant},
        PERF ? 64'(e_dg) : 64'd0);
    chk({nm, "_wt"}, {32'h0, perf_wait},
        PERF ? 64'(e_wt) : 64'd0);
  endtask

  function automatic logic [63:0] flags();
    return 64'({ibus_reqack, dbus_reqack,
                ibus_respcyc, dbus_respcyc,
                bus_reqcyc, bus_respack});
  endfunction

  task automatic idle_all();
    ibus_reqcyc  = 1'b0;
    dbus_reqcyc  = 1'b0;
    ibus_respack = 1'b0;
    dbus_respack = 1'b0;
    bus_reqack   = 1'b0;
    bus_respcyc  = 1'b0;
    bus_resp     = 64'h0;
    bus_resptag  = 13'h0;
  endtask

  // Eight response beats to one owner; the other requester
  // raises reqcyc from beat index raise_at onward.
  task automatic resp8(input bit to_d, input int raise_at);
    for (int b = 0; b < 8; b++) begin
      @(negedge clk);
      bus_reqack  = 1'b1;
      bus_respcyc = 1'b1;
      bus_resp    = 64'hD00 + 64'(b);
      bus_resptag = 13'(b + 3);
      if (to_d) begin
        dbus_reqcyc  = 1'b0;
        dbus_respack = 1'b1;
        ibus_reqcyc  = (b >= raise_at);
      end else begin
        ibus_reqcyc  = 1'b0;
        ibus_respack = 1'b1;
        dbus_reqcyc  = (b >= raise_at);
      end
      #1;
      if (to_d) begin
        chk("d_resp", flags(), 64'b000101);
        chk("d_data", dbus_resp, 64'hD00 + 64'(b));
        chk("d_tag", 64'(dbus_resptag), 64'(b + 3));
      end else begin
        chk("i_resp", flags(), 64'b001001);
        chk("i_data", ibus_resp, 64'hD00 + 64'(b));
      end
      if (b >= raise_at) e_wt++;
    end
  endtask

  initial begin
    tbl[0]  = '{1, 0, 1, 0, 0, 0, 6'b000000};
    tbl[1]  = '{1, 0, 1, 0, 0, 0, 6'b100010};
    tbl[2]  = '{0, 0, 0, 1, 1, 1, 6'b001001};
    tbl[3]  = '{0, 0, 0, 1, 1, 1, 6'b001001};
    tbl[4]  = '{0, 0, 0, 1, 0, 1, 6'b001000};
    for (int i = 5; i <= 10; i++)
      tbl[i] = '{0, 0, 0, 1, 1, 1, 6'b001001};
    tbl[11] = '{0, 0, 0, 1, 1, 1, 6'b000001};
    tbl[12] = '{0, 0, 0, 0, 0, 0, 6'b000000};

    idle_all();
    ibus_req    = 64'h1000;
    dbus_req    = 64'h2000;
    ibus_reqtag = 13'h0021;
    dbus_reqtag = 13'h0042;
    reset       = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out", flags(), 64'd0);
    chk("rst_breq", bus_req, 64'd0);
    chk_perf("rst");
    @(negedge clk);
    reset = 1'b1;

    // Tie right after reset: dbus first, then ibus.
    @(negedge clk);
    ibus_reqcyc = 1'b1;
    dbus_reqcyc = 1'b1;
    #1;
    chk("a_idle", flags(), 64'd0);
    @(negedge clk);
    bus_reqack = 1'b1;
    #1;
    chk("a_dgrant", flags(), 64'b010010);
    chk("a_breq", bus_req, 64'h2000);
    chk("a_btag", 64'(bus_reqtag), 64'h42);
    e_dg++;
    e_wt++;
    resp8(1'b1, 0);
    @(negedge clk);
    idle_all();
    ibus_reqcyc = 1'b1;
    dbus_reqcyc = 1'b1;
    #1;
    chk("a_gap", flags(), 64'd0);
    @(negedge clk);
    bus_reqack = 1'b1;
    #1;
    chk("a_igrant", flags(), 64'b100010);
    chk("a_ibreq", bus_req, 64'h1000);
    e_ig++;
    e_wt++;
    resp8(1'b0, 8);
    @(negedge clk);
    idle_all();
    #1;
    chk("a_end", flags(), 64'd0);
    chk_perf("a");

    // Lone ibus read, one response stall, then a stray in IDLE.
    ibus_reqtag = 13'h0011;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      ibus_reqcyc  = tbl[i].ir;
      dbus_reqcyc  = tbl[i].dr;
      bus_reqack   = tbl[i].ba;
      bus_respcyc  = tbl[i].br;
      ibus_respack = tbl[i].ia;
      dbus_respack = tbl[i].da;
      bus_resp     = 64'hC0 + 64'(i);
      #1;
      chk($sformatf("tbl%0d", i), flags(), 64'(tbl[i].ex));
    end
    e_ig++;
    e_wt++;
    chk_perf("tbl");

    // dbus write: 9 accepted beats with reqack toggling.
    @(negedge clk);
    idle_all();
    dbus_reqcyc = 1'b1;
    dbus_reqtag = 13'h1005;
    #1;
    chk("w_idle", flags(), 64'd0);
    e_dg++;
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      bus_reqack = (k % 2 == 0);
      dbus_req   = 64'hB0 + 64'(k);
      #1;
      chk("w_req", flags(),
          64'({1'b0, bus_reqack, 2'b00, 1'b1, 1'b0}));
      chk("w_data", bus_req, 64'hB0 + 64'(k));
    end
    @(negedge clk);
    idle_all();
    bus_respcyc  = 1'b1;
    dbus_respack = 1'b1;
    #1;
    chk("w_noresp", flags(), 64'b000001);
    e_wt++;
    @(negedge clk);
    idle_all();
    #1;
    chk("w_end", flags(), 64'd0);

    // ibus waits behind a dbus read, raising at beat 4.
    @(negedge clk);
    dbus_reqcyc = 1'b1;
    dbus_reqtag = 13'h0033;
    dbus_req    = 64'h3000;
    #1;
    chk("x_idle", flags(), 64'd0);
    e_dg++;
    @(negedge clk);
    bus_reqack = 1'b1;
    #1;
    chk("x_dgrant", flags(), 64'b010010);
    resp8(1'b1, 3);
    @(negedge clk);
    idle_all();
    ibus_reqcyc = 1'b1;
    ibus_reqtag = 13'h0044;
    bus_reqack  = 1'b1;
    #1;
    chk("x_iwait", flags(), 64'd0);
    @(negedge clk);
    #1;
    chk("x_igrant", flags(), 64'b100010);
    e_ig++;
    chk_perf("x");

    // Reset during the third response beat.
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      ibus_reqcyc  = 1'b0;
      bus_reqack   = 1'b0;
      bus_respcyc  = 1'b1;
      ibus_respack = 1'b1;
      #1;
      chk("r_beat", flags(), 64'b001001);
    end
    bus_respcyc  = 1'b0;
    ibus_respack = 1'b0;
    reset        = 1'b0;
    #1;
    chk("r_async", flags(), 64'd0);
    chk("r_breq", bus_req, 64'd0);
    e_ig = 0;
    e_dg = 0;
    e_wt = 0;
    chk_perf("r");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    idle_all();
    dbus_reqcyc = 1'b1;
    dbus_reqtag = 13'h0055;
    #1;
    chk("r_idle", flags(), 64'd0);
    e_dg++;
    @(negedge clk);
    bus_reqack = 1'b1;
    #1;
    chk("r_dgrant", flags(), 64'b010010);
    resp8(1'b1, 8);
    @(negedge clk);
    idle_all();
    bus_respcyc  = 1'b1;
    dbus_respack = 1'b1;
    #1;
    chk("r_done", flags(), 64'b000001);
    e_wt++;
    @(negedge clk);
    idle_all();
    #1;
    chk_perf("post");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
